// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: sequences load/layer engine handshakes per layer.
// Define LAYER_SEQ_CTRL_ACK_TIMEOUT_EN to enable the busy-ack watchdog.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, abort          run request (level), cancel current run
//   num_layers            layer count, latched on accepted start
//   valid_ctrl_busy       load-engine busy
//   layer_ctrl_busy       layer-engine busy
//   mode                  0 IDLE, 1 LOAD, 2 LAYER, 3 DONE
//   layer_idx             current layer index
//   start_weights/input/valid_pipeline, start_layering  1-cycle pulses
//   busy, done, err       not-idle, run-complete pulse, sticky watchdog
module layer_seq_ctrl #(
  parameter int LAYER_W         = 4,
  parameter int ACK_TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [LAYER_W-1:0] num_layers,
  input  logic               valid_ctrl_busy,
  input  logic               layer_ctrl_busy,
  output logic [2:0]         mode,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               start_weights,
  output logic               start_input,
  output logic               start_valid_pipeline,
  output logic               start_layering,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_LOAD,
    S_WAIT_LOAD_ON,
    S_WAIT_LOAD_OFF,
    S_ISSUE_LAYER,
    S_WAIT_LAY_ON,
    S_WAIT_LAY_OFF,
    S_DONE
  } state_t;

  localparam logic [LAYER_W-1:0] IDX_MAX = '1;

  state_t             state, state_n;
  logic [LAYER_W-1:0] cnt_q, cnt_n;
  logic [LAYER_W-1:0] idx_n;
  logic               ld_n;
  logic               lay_n;
  logic               done_n;

`ifdef LAYER_SEQ_CTRL_ACK_TIMEOUT_EN
  localparam int WD_W = $clog2(ACK_TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_q, wd_n;
  logic            err_q, err_n;
`endif

  function automatic logic [2:0] mode_of(state_t s);
    logic [2:0] m;
    m = 3'd0;
    unique case (s)
      S_ISSUE_LOAD,
      S_WAIT_LOAD_ON,
      S_WAIT_LOAD_OFF: m = 3'd1;
      S_ISSUE_LAYER,
      S_WAIT_LAY_ON,
      S_WAIT_LAY_OFF:  m = 3'd2;
      S_DONE:          m = 3'd3;
      default:         m = 3'd0;
    endcase
    return m;
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    idx_n   = layer_idx;
    ld_n    = 1'b0;
    lay_n   = 1'b0;
    done_n  = 1'b0;
`ifdef LAYER_SEQ_CTRL_ACK_TIMEOUT_EN
    wd_n    = wd_q;
    err_n   = err_q;
`endif
    // Abort wins over every other transition, watchdog included.
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && !valid_ctrl_busy && !layer_ctrl_busy) begin
            cnt_n = num_layers;
            idx_n = '0;
`ifdef LAYER_SEQ_CTRL_ACK_TIMEOUT_EN
            err_n = 1'b0;
`endif
            state_n = (num_layers == '0) ? S_DONE : S_ISSUE_LOAD;
          end
        end
        S_ISSUE_LOAD: begin
          ld_n    = 1'b1;
          state_n = S_WAIT_LOAD_ON;
`ifdef LAYER_SEQ_CTRL_ACK_TIMEOUT_EN
          wd_n    = '0;
`endif
        end
        S_WAIT_LOAD_ON: begin
          if (valid_ctrl_busy) begin
            state_n = S_WAIT_LOAD_OFF;
          end
`ifdef LAYER_SEQ_CTRL_ACK_TIMEOUT_EN
          else if (wd_q == WD_LAST) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            wd_n = wd_q + 1'b1;
          end
`endif
        end
        S_WAIT_LOAD_OFF: begin
          if (!valid_ctrl_busy) state_n = S_ISSUE_LAYER;
        end
        S_ISSUE_LAYER: begin
          lay_n   = 1'b1;
          state_n = S_WAIT_LAY_ON;
`ifdef LAYER_SEQ_CTRL_ACK_TIMEOUT_EN
          wd_n    = '0;
`endif
        end
        S_WAIT_LAY_ON: begin
          if (layer_ctrl_busy) begin
            state_n = S_WAIT_LAY_OFF;
          end
`ifdef LAYER_SEQ_CTRL_ACK_TIMEOUT_EN
          else if (wd_q == WD_LAST) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            wd_n = wd_q + 1'b1;
          end
`endif
        end
        S_WAIT_LAY_OFF: begin
          if (!layer_ctrl_busy) begin
            if (layer_idx == cnt_q - 1'b1) begin
              state_n = S_DONE;
            end else begin
              // Saturate rather than wrap the index.
              if (layer_idx != IDX_MAX) idx_n = layer_idx + 1'b1;
              state_n = S_ISSUE_LOAD;
            end
          end
        end
        S_DONE: begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      cnt_q                <= '0;
      layer_idx            <= '0;
      mode                 <= 3'd0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      start_weights        <= 1'b0;
      start_input          <= 1'b0;
      start_valid_pipeline <= 1'b0;
      start_layering       <= 1'b0;
    end else begin
      state                <= state_n;
      cnt_q                <= cnt_n;
      layer_idx            <= idx_n;
      mode                 <= mode_of(state_n);
      busy                 <= (state_n != S_IDLE);
      done                 <= done_n;
      start_weights        <= ld_n;
      start_input          <= ld_n;
      start_valid_pipeline <= ld_n;
      start_layering       <= lay_n;
    end
  end

`ifdef LAYER_SEQ_CTRL_ACK_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_n;
      err_q <= err_n;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/layer_seq_ctrl.md
LAYER_SEQ_CTRL -- requirements
Module: layer_seq_ctrl

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL provide parameter LAYER_W, default 4, giving the width of the layer count and index.
REQ-003 SHALL provide parameter ACK_TIMEOUT_CYC, default 16, giving the busy-acknowledge watchdog limit in cycles.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  run request, level-sampled.
REQ-007 abort  in  1  cancel the current run.
REQ-008 num_layers  in  LAYER_W  number of layers to run; latched when start is accepted.
REQ-009 valid_ctrl_busy  in  1  load-engine busy.
REQ-010 layer_ctrl_busy  in  1  layer-engine busy.
REQ-011 mode  out  3  0 = IDLE, 1 = LOAD, 2 = LAYER, 3 = DONE.
REQ-012 layer_idx  out  LAYER_W  index of the current layer.
REQ-013 start_weights, start_input, start_valid_pipeline, start_layering  out  1 each  one-cycle start pulses.
REQ-014 busy  out  1  high whenever the state machine is not in IDLE.
REQ-015 done  out  1  one-cycle pulse at the end of a completed run.
REQ-016 err  out  1  sticky watchdog flag.

Function
REQ-017 States SHALL be IDLE, ISSUE_LOAD, WAIT_LOAD_ON, WAIT_LOAD_OFF, ISSUE_LAYER, WAIT_LAY_ON, WAIT_LAY_OFF, DONE.
REQ-018 In IDLE, start with both busy inputs low SHALL latch num_layers, clear layer_idx and clear err; start SHALL be ignored if either busy input is high.
REQ-019 If the latched count is 0, IDLE SHALL go to DONE; no start pulse is issued.
REQ-020 If the latched count is nonzero, IDLE SHALL go to ISSUE_LOAD.
REQ-021 All outputs SHALL be registered; the default value of every start pulse is 0 each cycle.
REQ-022 ISSUE_LOAD SHALL drive start_weights, start_input and start_valid_pipeline high together, visible for exactly one cycle beginning one edge after ISSUE_LOAD is entered, then go to WAIT_LOAD_ON.
REQ-023 WAIT_LOAD_ON SHALL go to WAIT_LOAD_OFF when valid_ctrl_busy is 1 (acknowledge).
REQ-024 WAIT_LOAD_OFF SHALL go to ISSUE_LAYER when valid_ctrl_busy is 0 (complete).
REQ-025 ISSUE_LAYER SHALL pulse start_layering for one cycle, then go to WAIT_LAY_ON.
REQ-026 WAIT_LAY_ON SHALL go to WAIT_LAY_OFF when layer_ctrl_busy is 1.
REQ-027 WAIT_LAY_OFF, when layer_ctrl_busy is 0, SHALL go to DONE if layer_idx equals the latched count minus 1.
REQ-028 Otherwise WAIT_LAY_OFF SHALL increment layer_idx (no wrap; the maximum is 2^LAYER_W - 1) and go to ISSUE_LOAD.
REQ-029 mode SHALL be 1 in the LOAD states, 2 in the LAYER states, 3 in DONE and 0 in IDLE.
REQ-030 DONE SHALL pulse done for one cycle, then go to IDLE; layer_idx holds its final value until the next accepted start.
REQ-031 abort high in any non-IDLE state SHALL force IDLE on the next edge with no done pulse and no start pulse that cycle; err is unchanged.
REQ-032 abort SHALL take priority over every other transition, including the watchdog.
REQ-033 abort in IDLE SHALL have no effect.
REQ-034 A busy input that is already high on entry to a WAIT_*_ON state SHALL count as acknowledge on that cycle.

Reset
REQ-035 rst_n low SHALL immediately force state IDLE.
REQ-036 rst_n low SHALL immediately force mode, layer_idx, all start pulses, busy, done, err and the watchdog counter to 0.
REQ-037 Reset mid-run SHALL abandon the run with no done pulse.

Configuration
REQ-038 With macro LAYER_SEQ_CTRL_ACK_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT_LOAD_ON or WAIT_LAY_ON and increment each cycle the expected busy input is low.
REQ-039 With the macro defined, on reaching ACK_TIMEOUT_CYC the block SHALL set err to 1 and go to IDLE with no done pulse.
REQ-040 Without the macro, WAIT_*_ON states SHALL wait indefinitely, err SHALL be constant 0 and no counter SHALL exist.

Verification
REQ-041 num_layers=3, each busy rising 2 cycles after its pulse and held 5 cycles -> 3 start_weights pulses and 3 start_layering pulses, layer_idx 0,1,2, one done, busy low after done.
REQ-042 num_layers=0 -> done pulses 2 cycles after start acceptance, zero start pulses, mode reads 3 for one cycle.
REQ-043 abort asserted in WAIT_LAY_OFF at layer_idx=1 of num_layers=4 -> IDLE next edge, no done; a following start with num_layers=1 completes normally.
REQ-044 Macro defined, ACK_TIMEOUT_CYC=16, valid_ctrl_busy held 0 -> err=1 and IDLE after 16 cycles in WAIT_LOAD_ON, no done; next start clears err.
REQ-045 start while layer_ctrl_busy=1 -> ignored, busy stays 0.
REQ-046 rst_n low during WAIT_LOAD_OFF -> all outputs 0 without a clock edge.
